// File: rtl/fp_addsub_arbiter.sv
// Round-robin arbiter that time-shares one FP_ADD_SUB unit among NUM_REQ requesters.
// Each issued op is tracked through the adder latency, and its result is routed back with an ID.
module fp_addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int FPU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arb_en,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_op,
    output logic [31:0]             fpu_in1,
    output logic [31:0]             fpu_in2,
    output logic                    fpu_en,
    input  logic [31:0]             fpu_out,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             resp_data,
    output logic                    busy,
    output logic [CNT_W-1:0]        op_count
);

    localparam int LAST = FPU_LAT - 1;

    logic [ID_W-1:0]    last_grant_reg;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [31:0]        a_arr [NUM_REQ];
    logic [31:0]        b_arr [NUM_REQ];
    logic [FPU_LAT-1:0] pipe_valid_reg;
    logic [ID_W-1:0]    pipe_id_reg [FPU_LAT];
    logic [CNT_W-1:0]   op_count_reg;
    logic               last_valid;
    logic [ID_W-1:0]    last_id;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi]     = req_a[32*gi +: 32];
            assign b_arr[gi]     = req_b[32*gi +: 32];
            assign req_ready[gi] = grant_valid && (grant_id == ID_W'(gi));
        end
    endgenerate

    // Search upward from the slot after the last winner, wrapping around.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_id    = '0;
        if (arb_en && rst_n) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_grant_reg) + k) % NUM_REQ;
                if (!grant_valid && req_valid[idx]) begin
                    grant_valid = 1'b1;
                    grant_id    = ID_W'(idx);
                end
            end
        end
    end

    // When idle, the adder is fed 0+0 so its output stays at a known value.
    always_comb begin
        fpu_in1 = 32'h0;
        fpu_in2 = 32'h0;
        fpu_en  = 1'b1;
        if (grant_valid) begin
            fpu_in1 = a_arr[grant_id];
            fpu_in2 = b_arr[grant_id];
            fpu_en  = req_op[grant_id];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= ID_W'(NUM_REQ - 1);
        end else if (grant_valid) begin
            last_grant_reg <= grant_id;
        end
    end

    // The tracking pipe mirrors the adder latency, and stage 0 captures the issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_reg <= '0;
            for (int s = 0; s < FPU_LAT; s++) begin
                pipe_id_reg[s] <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= grant_valid;
            pipe_id_reg[0]    <= grant_id;
            for (int s = 1; s < FPU_LAT; s++) begin
                pipe_valid_reg[s] <= pipe_valid_reg[s-1];
                pipe_id_reg[s]    <= pipe_id_reg[s-1];
            end
        end
    end

    assign last_valid = pipe_valid_reg[LAST];
    assign last_id    = pipe_id_reg[LAST];

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_resp
            assign resp_valid[gi] = last_valid && (last_id == ID_W'(gi));
        end
    endgenerate

    assign resp_id   = last_valid ? last_id : '0;
    assign resp_data = last_valid ? fpu_out : 32'h0;
    assign busy      = |pipe_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (last_valid && (op_count_reg != {CNT_W{1'b1}})) begin
            op_count_reg <= op_count_reg + CNT_W'(1);
        end
    end

    assign op_count = op_count_reg;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Randomised and directed bench for fp_addsub_arbiter. It uses a behavioural adder
// and a transaction-level model of grants, responses and the operation count.
module tb_fp_addsub_arbiter;

    localparam int N     = 4;
    localparam int ID_W  = 2;
    localparam int LAT   = 1;
    localparam int CNT_W = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arb_en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N-1:0]      req_op;
    logic [31:0]       fpu_in1;
    logic [31:0]       fpu_in2;
    logic              fpu_en;
    logic [31:0]       fpu_out;
    logic [N-1:0]      resp_valid;
    logic [ID_W-1:0]   resp_id;
    logic [31:0]       resp_data;
    logic              busy;
    logic [CNT_W-1:0]  op_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_last;
    int          m_cnt;
    bit          pend_v;
    int          pend_id;
    logic [31:0] pend_data;
    logic [31:0] obs_data;

    fp_addsub_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .FPU_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .fpu_in1(fpu_in1), .fpu_in2(fpu_in2), .fpu_en(fpu_en), .fpu_out(fpu_out),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e;
        if (x[30:0] == 31'h0) return 0.0;
        e = 11'(x[30:23]) + 11'd896;
        d = {x[31], e, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Behavioural FP_ADD_SUB: registered output, en=1 adds, en=0 subtracts.
    always @(posedge clk) begin
        fpu_out <= fpu_en ? r2sp(sp2r(fpu_in1) + sp2r(fpu_in2))
                          : r2sp(sp2r(fpu_in1) - sp2r(fpu_in2));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last  = N - 1;
        m_cnt   = 0;
        pend_v  = 1'b0;
        pend_id = 0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i]         = op;
    endtask

    // One cycle: check outputs at the falling edge, advance the model, then move past the rising edge.
    task automatic step();
        int          g;
        int          idx;
        logic [31:0] ea;
        logic [31:0] eb;
        @(negedge clk);
        g = -1;
        if (arb_en) begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        check("ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
        ea = (g >= 0) ? req_a[32*g +: 32] : 32'h0;
        eb = (g >= 0) ? req_b[32*g +: 32] : 32'h0;
        check("fpu_in1", fpu_in1, ea);
        check("fpu_in2", fpu_in2, eb);
        check("fpu_en", 32'(fpu_en), (g >= 0) ? 32'(req_op[g]) : 32'h1);
        check("resp_valid", 32'(resp_valid), pend_v ? 32'(1 << pend_id) : 32'h0);
        check("resp_data", resp_data, pend_v ? pend_data : 32'h0);
        if (pend_v) check("resp_id", 32'(resp_id), 32'(pend_id));
        check("busy", 32'(busy), 32'(pend_v));
        check("op_count", 32'(op_count), 32'(m_cnt));
        obs_data = resp_data;
        if (pend_v) begin
            $display("resp id=%0d data=%h count=%0d", resp_id, resp_data, op_count);
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        if (g >= 0) begin
            pend_v    = 1'b1;
            pend_id   = g;
            pend_data = req_op[g] ? r2sp(sp2r(ea) + sp2r(eb)) : r2sp(sp2r(ea) - sp2r(eb));
            m_last    = g;
        end else begin
            pend_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_fp();
        return r2sp($itor($urandom_range(0, 2000)));
    endfunction

    initial begin
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(op_count), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b1;

        // Single request: 1.0 + 2.0
        set_req(0, 32'h3F800000, 32'h40000000, 1'b1);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        check("single_lit", obs_data, 32'h40400000);

        // Round-robin fairness with every requester always valid
        for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        step();

        // Subtract path: 3-1 and then a-a
        set_req(2, 32'h40400000, 32'h3F800000, 1'b0);
        req_valid = 4'b0100;
        step();
        set_req(2, 32'h40A00000, 32'h40A00000, 1'b0);
        step();
        check("sub_lit", obs_data, 32'h40000000);
        req_valid = '0;
        step();
        check("sub_zero_lit", obs_data, 32'h00000000);

        // arb_en gating after a req0 op, so req1 is next in line
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1010;
        arb_en    = 1'b0;
        repeat (3) step();
        arb_en = 1'b1;
        repeat (4) step();
        req_valid = '0;
        step();

        // Asynchronous reset in the response cycle of an issued op
        set_req(1, rnd_fp(), rnd_fp(), 1'b1);
        req_valid = 4'b0010;
        step();
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_count", 32'(op_count), 32'h0);
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_rst_grant", 32'(m_last), 32'h0);
        req_valid = '0;
        step();

        // Random traffic, long enough to saturate the counter
        for (int c = 0; c < 300; c++) begin
            arb_en    = ($urandom_range(0, 9) != 0);
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom_range(0, 1)));
            step();
        end
        req_valid = '0;
        repeat (2) step();
        check("sat_lit", 32'(op_count), 32'h3F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
